// File: rtl/imm_gen_pkg.sv
// ---------------------------------------------------------------------------
// imm_gen_pkg
// Shared types and constants for the decode-stage immediate generator.
//
// Contents:
//   imm_fmt_e    - 3-bit immediate format tag reported with each result
//   OPC_*        - RV base opcodes (instr[6:0]) the generator understands
//   XLEN_MAX     - widest datapath the generator supports
//   imm_entry_t  - one buffered entry laid out at the widest XLEN
//   isKnownOpcode- true for any opcode of the base ISA at the given XLEN
//
// Optional feature macro used by the users of this package:
//   IMM_GEN_ILLEGAL_EN - adds illegal-instruction flagging to the pipeline
// ---------------------------------------------------------------------------
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam int XLEN_MAX = 64;

    // Widest-case view of one buffered entry. The pipeline keeps the same
    // fields, but sized to its own XLEN so no dead upper bits are stored.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_e            fmt;
        logic [XLEN_MAX-1:0] pc;
        logic [31:0]         instr;
        logic                illegal;
    } imm_entry_t;

    // The *_32 word opcodes only exist on RV64, so the caller says which
    // base it is decoding for.
    function automatic logic isKnownOpcode(input logic [6:0] opc, input logic rv64);
        logic known;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_STORE, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_FENCE, OPC_SYSTEM:
                known = 1'b1;
            OPC_OP_IMM_32, OPC_OP_32:
                known = rv64;
            default:
                known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate decoder. Maps a 32-bit instruction word to
// its sign-extended immediate and the detected format.
//
// Parameters:
//   XLEN        - output immediate width, 32 or 64
// Ports:
//   i_instr     - instruction word
//   o_imm       - immediate sign-extended from instr[31] to XLEN
//   o_fmt       - detected format (FMT_NONE for opcodes without immediate)
//   o_illegal   - only with IMM_GEN_ILLEGAL_EN: unknown opcode or
//                 instr[1:0] != 2'b11
// ---------------------------------------------------------------------------
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_e        o_fmt
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic            o_illegal
`endif
);

    logic [6:0]         w_opcode;
    logic signed [31:0] w_imm32;
    imm_fmt_e           w_fmt;

    assign w_opcode = i_instr[6:0];

    // Build every immediate as a signed 32-bit value first; widening to XLEN
    // is a single signed cast afterwards, so each format only has to get its
    // bit scramble right once. Shift-amount immediates are deliberately not
    // special-cased: the consumer masks shamt itself.
    always_comb begin
        w_imm32 = '0;
        w_fmt   = FMT_NONE;
        case (w_opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                w_fmt   = FMT_I;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OPC_STORE: begin
                w_fmt   = FMT_S;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OPC_BRANCH: begin
                w_fmt   = FMT_B;
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                w_fmt   = FMT_U;
                w_imm32 = {i_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_fmt   = FMT_J;
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            end
            OPC_OP_IMM_32: begin
                // ADDIW and friends only exist on RV64; on RV32 this opcode
                // falls through as an opcode without an immediate.
                if (XLEN == 64) begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
            default: begin
                w_fmt   = FMT_NONE;
                w_imm32 = '0;
            end
        endcase
    end

    assign o_imm = XLEN'(w_imm32);
    assign o_fmt = w_fmt;

`ifdef IMM_GEN_ILLEGAL_EN
    // Every opcode that produces a format is a known opcode with
    // instr[1:0] == 2'b11, so illegal words already come out as imm 0 and
    // FMT_NONE from the decode above without extra gating.
    assign o_illegal = (i_instr[1:0] != 2'b11) || !isKnownOpcode(w_opcode, XLEN == 64);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Registered immediate generator for the decode stage. Each accepted
// instruction is decoded (imm_decode) and lands in a 2-entry skid-buffered
// output stage: a main register that drives the outputs and a skid register
// that absorbs one extra entry while the consumer stalls. in_ready is a
// register, so out_ready never reaches in_ready combinationally.
//
// Parameters:
//   XLEN        - datapath width, 32 or 64
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   flush       - synchronous flush, drops both held entries
//   in_valid    - instruction offered
//   in_ready    - registered, block can accept
//   in_instr    - instruction word
//   in_pc       - PC of the instruction, passed through
//   out_valid   - result valid
//   out_ready   - consumer accepts
//   out_imm     - decoded immediate
//   out_fmt     - detected format (imm_fmt_e)
//   out_pc      - pass-through PC
//   out_instr   - pass-through instruction word
//   out_illegal - only with IMM_GEN_ILLEGAL_EN: illegal-instruction flag
//
// Optional feature macro: IMM_GEN_ILLEGAL_EN
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_e        out_fmt,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    // Decoder results for the instruction currently offered
    logic [XLEN-1:0] w_decImm;
    imm_fmt_e        w_decFmt;
`ifdef IMM_GEN_ILLEGAL_EN
    logic            w_decIllegal;
`endif

    // Occupancy and the registered ready
    logic r_mainValid;
    logic r_skidValid;
    logic r_inReady;

    // Main entry (drives the outputs)
    logic [XLEN-1:0] r_mainImm;
    imm_fmt_e        r_mainFmt;
    logic [XLEN-1:0] r_mainPc;
    logic [31:0]     r_mainInstr;
`ifdef IMM_GEN_ILLEGAL_EN
    logic            r_mainIllegal;
`endif

    // Skid entry (holds one entry accepted while main was stalled)
    logic [XLEN-1:0] r_skidImm;
    imm_fmt_e        r_skidFmt;
    logic [XLEN-1:0] r_skidPc;
    logic [31:0]     r_skidInstr;
`ifdef IMM_GEN_ILLEGAL_EN
    logic            r_skidIllegal;
`endif

    // Handshake events and next-state controls
    logic w_accept;
    logic w_consume;
    logic w_loadMain;
    logic w_loadSkid;
    logic w_skidToMain;
    logic w_mainValidNext;
    logic w_skidValidNext;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_instr   (in_instr),
        .o_imm     (w_decImm),
        .o_fmt     (w_decFmt)
`ifdef IMM_GEN_ILLEGAL_EN
        ,
        .o_illegal (w_decIllegal)
`endif
    );

    assign w_accept  = in_valid && r_inReady;
    assign w_consume = r_mainValid && out_ready;

    // Decide where data moves this cycle. Flush wins over everything, which
    // also guarantees an input offered in the flush cycle is dropped. While
    // the skid is occupied r_inReady is low, so no new entry can arrive and
    // the only possible move is skid -> main once the consumer takes main.
    always_comb begin
        w_loadMain      = 1'b0;
        w_loadSkid      = 1'b0;
        w_skidToMain    = 1'b0;
        w_mainValidNext = r_mainValid;
        w_skidValidNext = r_skidValid;
        if (flush) begin
            w_mainValidNext = 1'b0;
            w_skidValidNext = 1'b0;
        end else if (r_skidValid) begin
            if (w_consume) begin
                w_skidToMain    = 1'b1;
                w_mainValidNext = 1'b1;
                w_skidValidNext = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_mainValid || w_consume) begin
                w_loadMain      = 1'b1;
                w_mainValidNext = 1'b1;
            end else begin
                w_loadSkid      = 1'b1;
                w_skidValidNext = 1'b1;
            end
        end else if (w_consume) begin
            w_mainValidNext = 1'b0;
        end
    end

    // Occupancy flags. in_ready is derived from the next skid state so it is
    // already correct in the cycle after the skid fills or drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
        end else begin
            r_mainValid <= w_mainValidNext;
            r_skidValid <= w_skidValidNext;
            r_inReady   <= !w_skidValidNext;
        end
    end

    // Main data only changes when something is loaded into it, which keeps
    // the outputs stable for as long as the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainImm     <= '0;
            r_mainFmt     <= FMT_NONE;
            r_mainPc      <= '0;
            r_mainInstr   <= '0;
`ifdef IMM_GEN_ILLEGAL_EN
            r_mainIllegal <= 1'b0;
`endif
        end else if (w_loadMain) begin
            r_mainImm     <= w_decImm;
            r_mainFmt     <= w_decFmt;
            r_mainPc      <= in_pc;
            r_mainInstr   <= in_instr;
`ifdef IMM_GEN_ILLEGAL_EN
            r_mainIllegal <= w_decIllegal;
`endif
        end else if (w_skidToMain) begin
            r_mainImm     <= r_skidImm;
            r_mainFmt     <= r_skidFmt;
            r_mainPc      <= r_skidPc;
            r_mainInstr   <= r_skidInstr;
`ifdef IMM_GEN_ILLEGAL_EN
            r_mainIllegal <= r_skidIllegal;
`endif
        end
    end

    // Skid data is captured straight from the decoder when main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skidImm     <= '0;
            r_skidFmt     <= FMT_NONE;
            r_skidPc      <= '0;
            r_skidInstr   <= '0;
`ifdef IMM_GEN_ILLEGAL_EN
            r_skidIllegal <= 1'b0;
`endif
        end else if (w_loadSkid) begin
            r_skidImm     <= w_decImm;
            r_skidFmt     <= w_decFmt;
            r_skidPc      <= in_pc;
            r_skidInstr   <= in_instr;
`ifdef IMM_GEN_ILLEGAL_EN
            r_skidIllegal <= w_decIllegal;
`endif
        end
    end

    assign in_ready    = r_inReady;
    assign out_valid   = r_mainValid;
    assign out_imm     = r_mainImm;
    assign out_fmt     = r_mainFmt;
    assign out_pc      = r_mainPc;
    assign out_instr   = r_mainInstr;
`ifdef IMM_GEN_ILLEGAL_EN
    assign out_illegal = r_mainIllegal;
`endif

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It decodes all RV base immediate formats (I, S, B, U, J) at width XLEN and reports the detected format. Results pass through a 2-entry skid-buffered output stage with valid/ready handshakes, so `in_ready` is a registered signal and back-pressure never creates a combinational path. It sits between the fetch/IF-ID register and the register-read/execute stage, and supports a synchronous flush for branch redirect.

## Interface
- `XLEN`, 32: datapath width, legal values 32 or 64; immediates are sign-extended to XLEN.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; discards all held entries.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: registered; block can accept.
- `in_instr` in 32: instruction word.
- `in_pc` in XLEN: PC of instruction, passed through.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `out_imm` out XLEN: decoded immediate.
- `out_fmt` out 3: `imm_fmt_e` (NONE=0, I=1, S=2, B=3, U=4, J=5).
- `out_pc` out XLEN, `out_instr` out 32: pass-through.
- `out_illegal` out 1: present only with `IMM_GEN_ILLEGAL_EN`.

## Operation
- Opcode decode (instr[6:0]):
  - I format: 0000011, 0010011, 1100111, and 0011011 when XLEN=64. Imm = sext(instr[31:20]).
  - S format: 0100011. Imm = sext({instr[31:25], instr[11:7]}).
  - B format: 1100011. Imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U format: 0110111, 0010111. Imm = sext({instr[31:12], 12'b0}).
  - J format: 1101111. Imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Any other opcode: imm 0, fmt NONE.
- Sign extension always takes instr[31] up to XLEN-1. Shift-amount immediates are not special-cased; the consumer masks them.
- Storage consists of a main register (drives outputs) and a skid register.
  - Accept happens when `in_valid && in_ready`.
  - If main is empty, or main is being consumed (`out_valid && out_ready`), and skid is empty: the new entry loads main.
  - If main is held (`out_valid && !out_ready`): the new entry loads skid.
  - When skid is valid and main is consumed: skid moves to main and skid clears.
  - `in_ready` next = !skid_valid next.
- Order is strictly preserved. No entry is dropped or duplicated except on flush.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on `out_*` after edge N, provided main was free.
- Throughput is 1 entry/cycle while `out_ready` is high.
- Reset values: out_valid 0, in_ready 1, out_imm 0, out_fmt NONE, out_pc 0, out_instr 0, out_illegal 0. Skid is empty.
- Flush: at the next edge both valids clear and in_ready goes to 1. An `in_valid` in the same cycle as flush is not accepted. Flush has priority over every other event.
- `out_*` data is stable while `out_valid && !out_ready`.
- Reset asserted mid-transfer empties the block immediately. No handshake completes in that cycle.
- Skid full with main held: in_ready is 0, and no state changes until `out_ready` goes high.

## Configuration
- `IMM_GEN_ILLEGAL_EN` defined:
  - `out_illegal` port exists. It is set for instr[1:0] != 2'b11, or for an opcode outside {I/S/B/U/J set, 0110011, 0001111, 1110011, plus 0111011 when XLEN=64}.
  - Illegal entries still flow with imm 0 and fmt NONE.
- `IMM_GEN_ILLEGAL_EN` undefined: the port and its logic are absent. Unknown opcodes yield fmt NONE and imm 0 only.

## Structure
- `imm_gen_pkg` holds:
  - `imm_fmt_e` enum, 3 bits.
  - Opcode constants (OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP_IMM_32, OPC_OP, OPC_OP_32, OPC_FENCE, OPC_SYSTEM).
  - Packed struct `imm_entry_t` {imm, fmt, pc, instr, illegal}.
- Sub-module `imm_decode`: purely combinational, parametrised by XLEN. It maps instr to imm/fmt/illegal. The top level owns the main/skid registers and the handshake.

## Test plan
- Reset then idle: all outputs hold their reset values and in_ready=1. Release rst_n mid-cycle: no spurious out_valid.
- Formats (XLEN=32, out_ready=1), each result 1 cycle after accept:
  - 0xFFF00093 → I, 0xFFFFFFFF.
  - 0x0020A423 → S, 0x00000008.
  - 0xFE000EE3 → B, 0xFFFFFFFC.
  - 0x123450B7 → U, 0x12345000.
  - 0x001000EF → J, 0x00000800.
- Back-pressure: stream A, B, C with out_ready=0.
  - A sits on the outputs and B goes to skid. in_ready drops after B, and C is held by the source.
  - Raise out_ready: the block outputs A, B, C in order with no loss.
- Flush with main and skid full plus in_valid high: next cycle out_valid=0, in_ready=1, and the flushing-cycle input is absent from the output.
- XLEN=64: 0xFFF00093 → imm 0xFFFFFFFFFFFFFFFF. Opcode 0011011 → I. With XLEN=32 the same opcode → NONE.
- With `IMM_GEN_ILLEGAL_EN`: 0x00000000 → out_illegal=1, fmt NONE. 0x00B50533 (add) → illegal=0, fmt NONE.
